// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a single-outstanding-request instruction
// memory port and presents one fetched word at a time to decode. A redirect
// re-targets the PC; a request already in flight when the redirect lands is
// allowed to complete and its data is thrown away.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] p_count,
    output logic        instr_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    logic        consume;

    // Decode takes the presented word whenever it is valid and not stalled.
    assign consume = valid_q & ~stall;

    // Next-state: redirect wins over everything; a new fetch is only issued
    // once the output slot is empty or being emptied this cycle, so an ack
    // in REQ always finds room for its data.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pcnt_d     = pcnt_q;
        valid_d    = valid_q & ~consume;
        misalign_d = redirect & (redirect_pc[1:0] != 2'b00);

        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!redirect && (!valid_q || consume)) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!redirect) begin
                        instr_d = imem_rdata;
                        pcnt_d  = addr_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + STEP;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn; wait it out in DROP.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            pcnt_q     <= 32'h0000_0000;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            pcnt_q     <= pcnt_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign p_count     = pcnt_q;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table with
// hand-computed expectations, then a reactive zero-wait memory run and an
// asynchronous-reset check.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic [31:0] p_count;
    logic        instr_valid;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .p_count(p_count),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        stall, ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc;
        logic        e_valid, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic r, input logic rd, input logic [31:0] rp,
                                 input logic st, input logic ak, input logic [31:0] rdat,
                                 input logic eq, input logic [31:0] ea, input logic [31:0] ei,
                                 input logic [31:0] ep, input logic ev, input logic em);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rp; v.stall = st; v.ack = ak; v.rdata = rdat;
        v.e_req = eq; v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002;
    localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004, A5 = 32'hA000_0005;
    localparam logic [31:0] A6 = 32'hA000_0006, A7 = 32'hA000_0007, A8 = 32'hA000_0008;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        logic [31:0] exp_pc[4];
        int nval;
        logic prev_v;

        //                rst rd rpc           st ak rdata   req addr          instr pcnt         v  m
        vecs.push_back(mkv(1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h0,         32'h0, 32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h0,         32'h0, 32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A0,     0, 32'h0,         A0,    32'h0,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h4,         A0,    32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A1,     0, 32'h4,         A1,    32'h4,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h8,         A1,    32'h4,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A2,     0, 32'h8,         A2,    32'h8,      1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(0, 0, 32'h0,     1, 0, 32'h0,  0, 32'h8,         A2,    32'h8,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'hC,         A2,    32'h8,      0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(0, 0, 32'h0,     0, 0, 32'h0,  1, 32'hC,         A2,    32'h8,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A3,     0, 32'hC,         A3,    32'hC,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h10,        A3,    32'hC,      0, 0));
        vecs.push_back(mkv(0, 1, 32'h100,       0, 0, 32'h0,  1, 32'h10,        A3,    32'hC,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h10,        A3,    32'hC,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, BAD,    0, 32'h10,        A3,    32'hC,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h100,       A3,    32'hC,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A4,     0, 32'h100,       A4,    32'h100,    1, 0));
        vecs.push_back(mkv(0, 1, 32'h203,       1, 0, 32'h0,  0, 32'h100,       A4,    32'h100,    0, 1));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h200,       A4,    32'h100,    0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A5,     0, 32'h200,       A5,    32'h200,    1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h204,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 1, 32'h300,       0, 1, BAD,    0, 32'h204,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h300,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 1, 32'h400,       0, 0, 32'h0,  1, 32'h300,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 1, 32'h500,       0, 0, 32'h0,  1, 32'h300,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, BAD,    0, 32'h300,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h500,       A5,    32'h200,    0, 0));
        vecs.push_back(mkv(1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h0,         32'h0, 32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, BAD,    1, 32'h0,         32'h0, 32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A6,     0, 32'h0,         A6,    32'h0,      1, 0));
        vecs.push_back(mkv(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  0, 32'h0,         A6,    32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'hFFFF_FFFC, A6,    32'h0,      0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A7,     0, 32'hFFFF_FFFC, A7,    32'hFFFF_FFFC, 1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h0,         A7,    32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mkv(0, 0, 32'h0,         0, 1, A8,     0, 32'h0,         A8,    32'h0,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h3,         1, 0, 32'h0,  0, 32'h0,         A8,    32'h0,      1, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            stall = vecs[i].stall; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            chk("imem_req",    i, {31'd0, imem_req},    {31'd0, vecs[i].e_req});
            chk("imem_addr",   i, imem_addr,            vecs[i].e_addr);
            chk("instruction", i, instruction,          vecs[i].e_instr);
            chk("p_count",     i, p_count,              vecs[i].e_pc);
            chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk("misalign",    i, {31'd0, misalign},    {31'd0, vecs[i].e_mis});
            @(negedge clk);
        end

        // Zero-wait memory: ack follows req combinationally-in-effect each cycle.
        redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        nval = 0;
        prev_v = 1'b0;
        for (int c = 0; c < 20 && nval < 4; c++) begin
            imem_ack   = imem_req;
            imem_rdata = 32'hC0DE_0000 | imem_addr;
            @(posedge clk);
            #1;
            if (instr_valid) begin
                chk("zw_p_count", nval, p_count, exp_pc[nval]);
                chk("zw_instr",   nval, instruction, 32'hC0DE_0000 | exp_pc[nval]);
                chk("zw_toggle",  nval, {31'd0, prev_v}, 32'd0);
                nval++;
            end
            prev_v = instr_valid;
            @(negedge clk);
        end
        chk("zw_count", 0, nval, 4);

        // Asynchronous reset mid-request, then a late ack.
        imem_ack = 1'b0;
        @(negedge clk);
        chk("ar_req_before", 0, {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req_async",  0, {31'd0, imem_req}, 32'd0);
        chk("ar_addr_async", 0, imem_addr, 32'h0);
        chk("ar_pc_async",   0, p_count, 32'h0);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = BAD;
        @(posedge clk);
        #1;
        chk("ar_late_valid", 0, {31'd0, instr_valid}, 32'd0);
        chk("ar_first_req",  0, {31'd0, imem_req}, 32'd1);
        chk("ar_first_addr", 0, imem_addr, 32'h0);
        imem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
